// File: rtl/stdp_lif_core.sv
// rtl/stdp_lif_core.sv - N_PRE-input LIF neuron with saturating pair-based STDP weights.
// Optional WEIGHT_LOAD_EN adds a direct weight write port (w_load/w_addr/w_data).
module stdp_lif_core #(
    parameter int N_PRE      = 4,
    parameter int W_WIDTH    = 8,
    parameter int V_WIDTH    = 8,
    parameter int THRESHOLD  = 100,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRACT    = 2,
    parameter int WINDOW     = 8,
    parameter int A_PLUS     = 16,
    parameter int A_MINUS    = 16,
    parameter int W_INIT     = 40,
    localparam int AW        = (N_PRE > 1) ? $clog2(N_PRE) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       learn_en,
    input  logic [N_PRE-1:0]           pre_spike,
`ifdef WEIGHT_LOAD_EN
    input  logic                       w_load,
    input  logic [AW-1:0]              w_addr,
    input  logic [W_WIDTH-1:0]         w_data,
`endif
    output logic                       post_spike,
    output logic [V_WIDTH-1:0]         post_state,
    output logic [N_PRE*W_WIDTH-1:0]   weights
);
    localparam int SYN_W  = W_WIDTH + $clog2(N_PRE) + 1;
    localparam int CALC_W = ((SYN_W > V_WIDTH) ? SYN_W : V_WIDTH) + 1;
    localparam int AGE_W  = $clog2(WINDOW + 1);
    localparam int RF_W   = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    localparam logic [CALC_W-1:0] THR_C  = CALC_W'(THRESHOLD);
    localparam logic [CALC_W-1:0] VMAX_C = CALC_W'((2 ** V_WIDTH) - 1);
    localparam logic [AGE_W-1:0]  WIN_C  = AGE_W'(WINDOW);
    localparam logic [31:0]       WMAX32 = 32'((2 ** W_WIDTH) - 1);

    logic [V_WIDTH-1:0] v_q, v_d;
    logic [RF_W-1:0]    refr_q, refr_d;
    logic               spike_q, spike_d;
    logic [AGE_W-1:0]   post_age_q, post_age_d;
    logic [AGE_W-1:0]   pre_age_q [N_PRE];
    logic [AGE_W-1:0]   pre_age_d [N_PRE];
    logic [W_WIDTH-1:0] w_q [N_PRE];
    logic [W_WIDTH-1:0] w_d [N_PRE];

    logic [SYN_W-1:0]   syn;
    logic [CALC_W-1:0]  vn_raw, vn_sat;
    logic               fire;
    logic [AGE_W-1:0]   d;
    logic [31:0]        amt, acc;

    always_comb begin
        syn = '0;
        for (int i = 0; i < N_PRE; i++) begin
            if (pre_spike[i]) syn = syn + SYN_W'(w_q[i]);
        end
        vn_raw = CALC_W'(v_q) - CALC_W'(v_q >> LEAK_SHIFT) + CALC_W'(syn);
        vn_sat = (vn_raw > VMAX_C) ? VMAX_C : vn_raw;
        fire   = en && (refr_q == '0) && (vn_sat >= THR_C);

        v_d        = v_q;
        refr_d     = refr_q;
        spike_d    = 1'b0;
        post_age_d = post_age_q;
        for (int i = 0; i < N_PRE; i++) begin
            pre_age_d[i] = pre_age_q[i];
            w_d[i]       = w_q[i];
        end
        d   = '0;
        amt = '0;
        acc = '0;

        if (en) begin
            if (refr_q != '0) begin
                v_d    = '0;
                refr_d = refr_q - RF_W'(1);
            end else if (fire) begin
                v_d     = '0;
                refr_d  = RF_W'(REFRACT);
                spike_d = 1'b1;
            end else begin
                v_d = vn_sat[V_WIDTH-1:0];
            end
            post_age_d = fire ? AGE_W'(1)
                       : (post_age_q == WIN_C) ? WIN_C : post_age_q + AGE_W'(1);
            for (int i = 0; i < N_PRE; i++) begin
                pre_age_d[i] = pre_spike[i] ? AGE_W'(1)
                             : (pre_age_q[i] == WIN_C) ? WIN_C : pre_age_q[i] + AGE_W'(1);
                // A coincident pre spike counts as zero-age LTP and suppresses LTD.
                if (learn_en && fire) begin
                    d = pre_spike[i] ? '0 : pre_age_q[i];
                    if (d < WIN_C) begin
                        amt = 32'(A_PLUS) >> d;
                        acc = 32'(w_q[i]) + amt;
                        w_d[i] = (acc > WMAX32) ? W_WIDTH'(WMAX32) : W_WIDTH'(acc);
                    end
                end else if (learn_en && pre_spike[i] && (post_age_q < WIN_C)) begin
                    amt = 32'(A_MINUS) >> post_age_q;
                    w_d[i] = (amt > 32'(w_q[i])) ? '0 : W_WIDTH'(32'(w_q[i]) - amt);
                end
            end
        end
`ifdef WEIGHT_LOAD_EN
        for (int i = 0; i < N_PRE; i++) begin
            if (w_load && (32'(w_addr) == 32'(i))) w_d[i] = w_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q        <= '0;
            refr_q     <= '0;
            spike_q    <= 1'b0;
            post_age_q <= WIN_C;
            for (int i = 0; i < N_PRE; i++) begin
                pre_age_q[i] <= WIN_C;
                w_q[i]       <= W_WIDTH'(W_INIT);
            end
        end else begin
            v_q        <= v_d;
            refr_q     <= refr_d;
            spike_q    <= spike_d;
            post_age_q <= post_age_d;
            for (int i = 0; i < N_PRE; i++) begin
                pre_age_q[i] <= pre_age_d[i];
                w_q[i]       <= w_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_PRE; i++) weights[i*W_WIDTH +: W_WIDTH] = w_q[i];
    end

    assign post_spike = spike_q;
    assign post_state = v_q;
endmodule

// File: tb/tb_stdp_lif_core.sv
// tb/tb_stdp_lif_core.sv - directed and seeded-sweep bench for stdp_lif_core against a behavioural model.
module tb_stdp_lif_core;
    localparam int N = 4, WIN = 8, AP = 16, AM = 16, WI = 40, THR = 100;
    localparam int RF = 2, LEAK_DIV = 8, WMAX = 255, VMAX = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0, en = 1'b0, learn_en = 1'b0;
    logic [3:0]  pre_spike = '0;
    logic        post_spike;
    logic [7:0]  post_state;
    logic [31:0] weights;
`ifdef WEIGHT_LOAD_EN
    logic        w_load = 1'b0;
    logic [1:0]  w_addr = '0;
    logic [7:0]  w_data = '0;
`endif

    always #5 clk = ~clk;

    stdp_lif_core #(
        .N_PRE(4), .W_WIDTH(8), .V_WIDTH(8), .THRESHOLD(100), .LEAK_SHIFT(3), .REFRACT(2),
        .WINDOW(8), .A_PLUS(16), .A_MINUS(16), .W_INIT(40)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .learn_en(learn_en), .pre_spike(pre_spike),
`ifdef WEIGHT_LOAD_EN
        .w_load(w_load), .w_addr(w_addr), .w_data(w_data),
`endif
        .post_spike(post_spike), .post_state(post_state), .weights(weights)
    );

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wt(input int i);
        return 32'(weights[i*8 +: 8]);
    endfunction

    // Behavioural model: neuron and learning rules in plain integer arithmetic.
    int m_v, m_refr, m_spike, m_post_age;
    int m_pre_age [N];
    int m_w [N];
    bit m_valid = 0;

    always @(posedge clk) begin
        int syn, vn, dd, dw;
        bit fire;
        if (rst) begin
            m_v = 0; m_refr = 0; m_spike = 0; m_post_age = WIN;
            for (int i = 0; i < N; i++) begin m_pre_age[i] = WIN; m_w[i] = WI; end
            m_valid = 1;
        end else begin
            if (en) begin
                syn = 0;
                for (int i = 0; i < N; i++) if (pre_spike[i]) syn += m_w[i];
                fire = 0;
                if (m_refr > 0) begin
                    m_v = 0; m_refr--;
                end else begin
                    vn = m_v - m_v / LEAK_DIV + syn;
                    if (vn > VMAX) vn = VMAX;
                    if (vn >= THR) begin fire = 1; m_v = 0; m_refr = RF; end
                    else m_v = vn;
                end
                if (learn_en) begin
                    for (int i = 0; i < N; i++) begin
                        if (fire) begin
                            dd = pre_spike[i] ? 0 : m_pre_age[i];
                            if (dd < WIN) begin
                                dw = AP / (2 ** dd);
                                m_w[i] = (m_w[i] + dw > WMAX) ? WMAX : m_w[i] + dw;
                            end
                        end else if (pre_spike[i] && m_post_age < WIN) begin
                            dw = AM / (2 ** m_post_age);
                            m_w[i] = (m_w[i] - dw < 0) ? 0 : m_w[i] - dw;
                        end
                    end
                end
                for (int i = 0; i < N; i++)
                    m_pre_age[i] = pre_spike[i] ? 1 : ((m_pre_age[i] + 1 > WIN) ? WIN : m_pre_age[i] + 1);
                m_post_age = fire ? 1 : ((m_post_age + 1 > WIN) ? WIN : m_post_age + 1);
                m_spike = fire ? 1 : 0;
            end else begin
                m_spike = 0;
            end
`ifdef WEIGHT_LOAD_EN
            if (w_load && int'(w_addr) < N) m_w[w_addr] = int'(w_data);
`endif
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_post_spike", 32'(post_spike), 32'(m_spike));
            check("model_post_state", 32'(post_state), 32'(m_v));
            for (int i = 0; i < N; i++) check($sformatf("model_w%0d", i), wt(i), 32'(m_w[i]));
        end
    end

    task automatic cyc(input bit r, input bit e, input bit l, input logic [3:0] p);
        rst = r; en = e; learn_en = l; pre_spike = p;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        cyc(1, 0, 0, 4'b0000);
        check("rst_state", 32'(post_state), 0);
        check("rst_spike", 32'(post_spike), 0);
        for (int i = 0; i < N; i++) check("rst_weight", wt(i), 40);

        // Integration, fire, refractory, re-integration with learning off
        cyc(0, 1, 0, 4'b0011); check("t2_state_80", 32'(post_state), 80);
        cyc(0, 1, 0, 4'b0011); check("t2_fire", 32'(post_spike), 1); check("t2_fire_state", 32'(post_state), 0);
        cyc(0, 1, 0, 4'b0011); check("t2_refr1_spike", 32'(post_spike), 0); check("t2_refr1_state", 32'(post_state), 0);
        cyc(0, 1, 0, 4'b0011); check("t2_refr2_state", 32'(post_state), 0);
        cyc(0, 1, 0, 4'b0011); check("t2_again_80", 32'(post_state), 80);
        for (int i = 0; i < N; i++) check("t2_weight_frozen", wt(i), 40);

        // LTP on coincident fire, then LTD at post_age 3
        cyc(1, 0, 0, 4'b0000);
        cyc(0, 1, 1, 4'b1111); check("t3_fire", 32'(post_spike), 1);
        for (int i = 0; i < N; i++) check("t3_ltp_56", wt(i), 56);
        cyc(0, 1, 1, 4'b0000);
        cyc(0, 1, 1, 4'b0000);
        cyc(0, 1, 1, 4'b0010);
        check("t4_w1_54", wt(1), 54); check("t4_w0_56", wt(0), 56);
        check("t4_w3_56", wt(3), 56); check("t4_no_fire", 32'(post_spike), 0);

        // Enable freeze mid-integration, reset mid-refractory
        cyc(1, 0, 0, 4'b0000);
        cyc(0, 1, 0, 4'b0001); check("t6_state_40", 32'(post_state), 40);
        cyc(0, 1, 0, 4'b0001); check("t6_state_75", 32'(post_state), 75);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 1, 4'b0001);
            check("t6_hold_state", 32'(post_state), 75);
            check("t6_hold_spike", 32'(post_spike), 0);
            check("t6_hold_w0", wt(0), 40);
        end
        cyc(0, 1, 0, 4'b0001); check("t6_fire_106", 32'(post_spike), 1);
        cyc(1, 1, 0, 4'b0001);
        cyc(0, 1, 0, 4'b0001); check("t6_post_rst_40", 32'(post_state), 40);
        check("t6_post_rst_spike", 32'(post_spike), 0);

`ifdef WEIGHT_LOAD_EN
        // Direct load then LTP clip at max; load overriding during fire, LTD clip at zero
        cyc(1, 0, 0, 4'b0000);
        w_load = 1; w_addr = 2'd0; w_data = 8'd250;
        cyc(0, 0, 0, 4'b0000);
        check("t5_load_250", wt(0), 250);
        w_addr = 2'd2; w_data = 8'd5;
        cyc(0, 1, 1, 4'b0001);
        w_load = 0;
        check("t5_clip_255", wt(0), 255); check("t5_load_w2_5", wt(2), 5);
        cyc(0, 1, 1, 4'b0100);
        check("t5_ltd_clip_0", wt(2), 0);
`endif

        // Seeded sweep checked by the model
        cyc(1, 0, 0, 4'b0000);
        for (int k = 0; k < 120; k++)
            cyc(0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
